// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with configurable data width and bit period; start, LSB-first data, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to build the parity stage; without it parity_en/parity_odd are ignored and frames carry no parity bit.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = 2604
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 stop2,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 TX,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t               r_state;
  logic [BW-1:0]        r_baud;
  logic [NW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop2;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_tick;
`ifdef UART_TX_PARITY_EN
  logic                 r_par_en;
  logic                 r_par;
`else
  logic                 w_unused_par;
  assign w_unused_par = parity_en ^ parity_odd;
`endif
  assign w_tick  = r_baud == BAUD_LAST;
  assign TX      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_stop2  <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
`endif
    end else begin
      r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
      case (r_state)
        IDLE: if (trmt) begin
          r_shift  <= tx_data;
          r_stop2  <= stop2;
`ifdef UART_TX_PARITY_EN
          r_par_en <= parity_en;
          r_par    <= ^tx_data ^ parity_odd;
`endif
          r_bit    <= '0;
          r_done   <= 1'b0;
          r_busy   <= 1'b1;
          r_tx     <= 1'b0;
          r_state  <= START;
        end
        START: if (w_tick) begin
          r_tx    <= r_shift[0];
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 1'b1;
          r_tx    <= r_shift[1];
          if (r_bit == BIT_LAST) begin
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_tx    <= r_par_en ? r_par : 1'b1;
            r_state <= r_par_en ? PARITY : STOP;
`else
            r_tx    <= 1'b1;
            r_state <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (w_tick) begin
          r_tx    <= 1'b1;
          r_state <= STOP;
        end
`endif
        STOP: if (w_tick) begin
          if (r_stop2 && r_bit == '0) r_bit <= NW'(1);
          else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg (8 bits / 16 clks and 7 bits / 5 clks instances).
module tb_uart_tx_cfg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt1 = 1'b0;
  logic       trmt2 = 1'b0;
  logic       stop2 = 1'b0;
  logic       pe = 1'b0;
  logic       po = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx1, busy1, done1, tx2, busy2, done2;
  int         total = 0;
  int         bad = 0;
  always #5 clk = ~clk;
  uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIV(16)) dut (
    .clk(clk), .rst(rst), .trmt(trmt1), .tx_data(tx_data), .stop2(stop2),
    .parity_en(pe), .parity_odd(po), .TX(tx1), .busy(busy1), .tx_done(done1)
  );
  uart_tx_cfg #(.DATA_BITS(7), .BAUD_DIV(5)) dut7 (
    .clk(clk), .rst(rst), .trmt(trmt2), .tx_data(tx_data[6:0]), .stop2(stop2),
    .parity_en(pe), .parity_odd(po), .TX(tx2), .busy(busy2), .tx_done(done2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Call at a negedge; the frame's trmt is sampled on the next posedge.
  task automatic frame(input string tag, input bit sel, input logic [7:0] d, input bit s2,
                       input bit p_en, input bit p_odd, input int div, input int nb,
                       input logic [11:0] exp, input int poke1, input int poke2);
    logic [11:0] got;
    got = '0;
    tx_data = d; stop2 = s2; pe = p_en; po = p_odd;
    trmt1 = !sel; trmt2 = sel;
    @(negedge clk);
    trmt1 = 1'b0; trmt2 = 1'b0;
    tx_data = 8'h00; stop2 = ~s2; pe = ~p_en; po = ~p_odd;
    chk({tag, ".start_busy"}, sel ? busy2 : busy1, 1);
    chk({tag, ".start_tx"}, sel ? tx2 : tx1, 0);
    chk({tag, ".start_done"}, sel ? done2 : done1, 0);
    for (int c = 1; c <= nb * div; c++) begin
      @(negedge clk);
      trmt1 = !sel && (c == poke1 || c == poke2);
      trmt2 = sel && (c == poke1 || c == poke2);
      if (c % div == div / 2) got[c / div] = sel ? tx2 : tx1;
      if (c == nb * div - 1) begin
        chk({tag, ".last_busy"}, sel ? busy2 : busy1, 1);
        chk({tag, ".last_done"}, sel ? done2 : done1, 0);
      end
    end
    trmt1 = 1'b0; trmt2 = 1'b0;
    chk({tag, ".bits"}, got, exp);
    chk({tag, ".end_busy"}, sel ? busy2 : busy1, 0);
    chk({tag, ".end_done"}, sel ? done2 : done1, 1);
    chk({tag, ".end_tx"}, sel ? tx2 : tx1, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst.tx", tx1, 1);
    chk("rst.busy", busy1, 0);
    chk("rst.done", done1, 0);
    chk("rst.tx7", tx2, 1);
    chk("rst.busy7", busy2, 0);
    chk("rst.done7", done2, 0);
    rst = 1'b0;
    frame("t1", 0, 8'hA5, 0, 0, 0, 16, 10, 12'h34A, -1, -1);
    repeat (2) @(negedge clk);
`ifdef UART_TX_PARITY_EN
    frame("t2_even", 0, 8'hA5, 0, 1, 0, 16, 11, 12'h54A, -1, -1);
    repeat (2) @(negedge clk);
    frame("t2_odd", 0, 8'hA5, 0, 1, 1, 16, 11, 12'h74A, -1, -1);
`else
    frame("t2_even", 0, 8'hA5, 0, 1, 0, 16, 10, 12'h34A, -1, -1);
    repeat (2) @(negedge clk);
    frame("t2_odd", 0, 8'hA5, 0, 1, 1, 16, 10, 12'h34A, -1, -1);
`endif
    repeat (2) @(negedge clk);
    frame("t3_stop2", 0, 8'h3C, 1, 0, 0, 16, 11, 12'h678, -1, -1);
    frame("t3_b2b", 0, 8'hA5, 0, 0, 0, 16, 10, 12'h34A, -1, -1);
    repeat (2) @(negedge clk);
    frame("t4", 0, 8'hFF, 0, 0, 0, 16, 10, 12'h3FE, 40, 159);
    @(negedge clk);
    chk("t4.ignored_busy", busy1, 0);
    chk("t4.ignored_done", done1, 1);
    chk("t4.ignored_tx", tx1, 1);
    tx_data = 8'h00; stop2 = 0; pe = 0; po = 0; trmt1 = 1'b1;
    @(negedge clk);
    trmt1 = 1'b0;
    repeat (69) @(negedge clk);
    chk("t5.pre_tx", tx1, 0);
    chk("t5.pre_busy", busy1, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5.rst_tx", tx1, 1);
    chk("t5.rst_busy", busy1, 0);
    chk("t5.rst_done", done1, 0);
    rst = 1'b0;
    @(negedge clk);
    frame("t5", 0, 8'h55, 0, 0, 0, 16, 10, 12'h2AA, -1, -1);
    repeat (2) @(negedge clk);
    frame("t6", 1, 8'h41, 0, 0, 0, 5, 9, 12'h182, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
